fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 20 ++
 rtl/fetch_unit_npc_calc.sv | 31 +++
 rtl/fetch_unit.sv | 91 +++++++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared fetch/decode definitions: fetch FSM states, reset PC and the
// opcode/funct encodings the decoder uses to raise ifb/ifj/ifjr.
package fetch_unit_pkg;

    typedef enum logic {
        ST_REQ  = 1'b0,
        ST_HOLD = 1'b1
    } fetch_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] FN_JR      = 6'h08;
    localparam logic [5:0] FN_JALR    = 6'h09;

endpackage

// File: rtl/fetch_unit_npc_calc.sv
// Next-PC selection for the instruction held in D: jr, j, taken branch,
// otherwise sequential fetch.
module npc_calc (
    input  logic [31:0] pc_F,
    input  logic [31:0] pc_D,
    input  logic [31:0] instr_D,
    input  logic        ifb,
    input  logic        br_taken,
    input  logic        ifj,
    input  logic        ifjr,
    input  logic [31:0] jr_target,
    output logic [31:0] npc
);

    logic signed [31:0] br_off;

    // Word offset, sign-extended and scaled to bytes.
    assign br_off = {{14{instr_D[15]}}, instr_D[15:0], 2'b00};

    always_comb begin
        npc = pc_F + 32'd4;
        if (ifjr) begin
            npc = jr_target;
        end else if (ifj) begin
            npc = {pc_D[31:28], instr_D[25:0], 2'b00};
        end else if (ifb && br_taken) begin
            npc = pc_D + 32'd4 + $unsigned(br_off);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage with IF/ID register. A word that returns while
// decode is stalled is parked in a one-entry buffer until the stall clears.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_i,
    input  logic        ifb,
    input  logic        ifj,
    input  logic        ifjr,
    input  logic        br_taken,
    input  logic [31:0] jr_target,
    output logic        im_req,
    output logic [31:0] im_addr,
    input  logic        im_ack,
    input  logic [31:0] im_rdata,
    output logic [31:0] instr_D,
    output logic [31:0] pc_D,
    output logic        d_adv
);

    fetch_state_t state, state_nx;
    logic [31:0]  pc_F;
    logic [31:0]  fetch_buf;
    logic [31:0]  fetched;
    logic [31:0]  npc;
    logic         hold;
    logic         adv;
    logic         park;

    // Request is masked during reset so an abandoned fetch is never re-driven.
    assign im_req  = (state == ST_REQ) && !reset;
    assign hold    = (state == ST_HOLD);
    assign im_addr = pc_F;
    assign adv     = ((im_req && im_ack) || hold) && !stall_i;
    assign park    = im_req && im_ack && stall_i;
    assign d_adv   = adv;
    assign fetched = hold ? fetch_buf : im_rdata;

    npc_calc u_npc (
        .pc_F      (pc_F),
        .pc_D      (pc_D),
        .instr_D   (instr_D),
        .ifb       (ifb),
        .br_taken  (br_taken),
        .ifj       (ifj),
        .ifjr      (ifjr),
        .jr_target (jr_target),
        .npc       (npc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_REQ;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_REQ:  if (park) state_nx = ST_HOLD;
            ST_HOLD: if (!stall_i) state_nx = ST_REQ;
            default: state_nx = ST_REQ;
        endcase
    end

    // Controls are consumed only on advance, so a held jump redirects once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_F      <= RESET_PC;
            pc_D      <= 32'h0;
            instr_D   <= 32'h0;
            fetch_buf <= 32'h0;
        end else begin
            if (park) begin
                fetch_buf <= im_rdata;
            end
            if (adv) begin
                instr_D <= fetched;
                pc_D    <= pc_F;
                pc_F    <= {npc[31:2], 2'b00};
            end
        end
    end

endmodule
